// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: syscall FSM states and forward-select codes.
// Forward selects drive the Execute operand muxes directly; no latency or backpressure.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DRAIN = 2'b01,
    S_GO    = 2'b10
  } sysState_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: stage register IDs and enables in, stall/flush/forward controls out.
// Purely wire-level; the hazard unit answers in the same cycle and applies no backpressure.
interface hazard_ctrl_if #(
  parameter int REG_AW = 4
);
  logic [REG_AW-1:0] RsD;
  logic [REG_AW-1:0] RtD;
  logic              BranchD;
  logic              SyscallD;
  logic [REG_AW-1:0] RsE;
  logic [REG_AW-1:0] RtE;
  logic [REG_AW-1:0] WriteRegE;
  logic              MemtoRegE;
  logic              RegWriteE;
  logic              McStartE;
  logic [REG_AW-1:0] WriteRegM;
  logic              MemtoRegM;
  logic              RegWriteM;
  logic [REG_AW-1:0] WriteRegW;
  logic              RegWriteW;

  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              SyscallGoD;
  logic              McBusy;

  modport master (
    output RsD, RtD, BranchD, SyscallD,
    output RsE, RtE, WriteRegE, MemtoRegE, RegWriteE, McStartE,
    output WriteRegM, MemtoRegM, RegWriteM,
    output WriteRegW, RegWriteW,
    input  StallF, StallD, StallE, FlushE,
    input  ForwardAE, ForwardBE, SyscallGoD, McBusy
  );

  modport slave (
    input  RsD, RtD, BranchD, SyscallD,
    input  RsE, RtE, WriteRegE, MemtoRegE, RegWriteE, McStartE,
    input  WriteRegM, MemtoRegM, RegWriteM,
    input  WriteRegW, RegWriteW,
    output StallF, StallD, StallE, FlushE,
    output ForwardAE, ForwardBE, SyscallGoD, McBusy
  );

endinterface

// File: rtl/mc_busy_counter.sv
// Occupancy counter for the multi-cycle Execute unit; busy rises the cycle after an accepted start.
// Starts arriving while busy are dropped, so the unit is never re-armed mid-operation.
module mc_busy_counter #(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  // The start cycle itself counts toward MC_LAT, so only MC_LAT-1 extra cycles are held.
  localparam logic [3:0] LOAD_VAL = 4'(MC_LAT - 1);

  logic [3:0] mcCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcCnt <= '0;
    end else if (mcCnt == '0) begin
      if (start) begin
        mcCnt <= LOAD_VAL;
      end
    end else begin
      mcCnt <= mcCnt - 4'd1;
    end
  end

  assign busy = (mcCnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: operand forwarding, load-use/branch/syscall stalls, multi-cycle Execute hold.
// Controls are combinational (zero latency); only the syscall FSM and busy counter are registered.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int ZERO_REG_EN = 1,
  parameter int MC_LAT      = 4,
  parameter int SYS_REG     = 1
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [REG_AW-1:0] SYS_ID = REG_AW'(SYS_REG);

  sysState_t state;
  sysState_t stateNext;

  logic lwStall;
  logic branchStall;
  logic sysStall;
  logic pending;
  logic mcBusy;
  logic anyStall;

  // Register 0 is a constant source when hardwired, so it never creates a dependency.
  function automatic logic regHit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && ((a != '0) || (ZERO_REG_EN == 0));
  endfunction

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    if (hz.RegWriteM && regHit(src, hz.WriteRegM)) begin
      return FWD_M;
    end else if (hz.RegWriteW && regHit(src, hz.WriteRegW)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  assign hz.ForwardAE = fwdSel(hz.RsE);
  assign hz.ForwardBE = fwdSel(hz.RtE);

  assign lwStall = hz.MemtoRegE & hz.RegWriteE &
                   (regHit(hz.RsD, hz.WriteRegE) | regHit(hz.RtD, hz.WriteRegE));

  // Branches resolve in Decode, so an ALU result still in E or a load still in M is not yet usable.
  assign branchStall = hz.BranchD &
                       ((hz.RegWriteE & (regHit(hz.RsD, hz.WriteRegE) | regHit(hz.RtD, hz.WriteRegE))) |
                        (hz.MemtoRegM & (regHit(hz.RsD, hz.WriteRegM) | regHit(hz.RtD, hz.WriteRegM))));

  assign pending = (hz.RegWriteE & (hz.WriteRegE == SYS_ID)) |
                   (hz.RegWriteM & (hz.WriteRegM == SYS_ID)) |
                   (hz.RegWriteW & (hz.WriteRegW == SYS_ID));

  mc_busy_counter #(
    .MC_LAT (MC_LAT)
  ) mcCounter (
    .clk   (clk),
    .rst   (rst),
    .start (hz.McStartE),
    .busy  (mcBusy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE: begin
        if (hz.SyscallD) begin
          stateNext = pending ? S_DRAIN : S_GO;
        end
      end
      S_DRAIN: begin
        if (!hz.SyscallD) begin
          stateNext = S_IDLE;
        end else if (!pending) begin
          stateNext = S_GO;
        end
      end
      S_GO:    stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    hz.SyscallGoD = (state == S_GO);
    sysStall      = hz.SyscallD & (state != S_GO);
  end

  assign anyStall   = lwStall | branchStall | sysStall;
  assign hz.McBusy  = mcBusy;
  assign hz.StallE  = mcBusy;
  assign hz.StallF  = anyStall | mcBusy;
  assign hz.StallD  = anyStall | mcBusy;
  // A bubble would discard the op the busy unit is still executing; hold E instead.
  assign hz.FlushE  = anyStall & ~mcBusy;

endmodule
